// File: rtl/braun8_seq.sv
// Sequential 8x8 unsigned multiplier that reuses one 4x4 Braun array over four cycles.
// It holds both the combinational array and the controller that drives it.

module braun (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] prod
);

    // Carry-save rows: row i adds x*y[i]; s bits weigh i+j, c bits weigh i+j+1.
    for (genvar i = 0; i < 4; i++) begin : g_row
        logic [3:0] s;
        logic [3:0] c;
        if (i == 0) begin : g_first
            assign s = x & {4{y[0]}};
            assign c = 4'b0000;
        end else begin : g_rest
            logic [3:0] pp_bits;
            logic [3:0] s_in;
            assign pp_bits = x & {4{y[i]}};
            assign s_in    = {1'b0, g_row[i-1].s[3:1]};
            assign s       = pp_bits ^ s_in ^ g_row[i-1].c;
            assign c       = (pp_bits & s_in) | (pp_bits & g_row[i-1].c)
                           | (s_in & g_row[i-1].c);
        end
    end

    logic [3:0] s3;
    logic [3:0] c3;
    logic       k4;
    logic       k5;
    logic       k6;

    assign s3 = g_row[3].s;
    assign c3 = g_row[3].c;

    // Final ripple-carry row resolves the remaining sum/carry vectors into bits 7:4.
    assign k4 = s3[1] & c3[0];
    assign k5 = (s3[2] & c3[1]) | (s3[2] & k4) | (c3[1] & k4);
    assign k6 = (s3[3] & c3[2]) | (s3[3] & k5) | (c3[2] & k5);

    assign prod[0] = g_row[0].s[0];
    assign prod[1] = g_row[1].s[0];
    assign prod[2] = g_row[2].s[0];
    assign prod[3] = s3[0];
    assign prod[4] = s3[1] ^ c3[0];
    assign prod[5] = s3[2] ^ c3[1] ^ k4;
    assign prod[6] = s3[3] ^ c3[2] ^ k5;
    assign prod[7] = c3[3] ^ k6;

endmodule

module braun8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [7:0]  ra_q, ra_d;
    logic [7:0]  rb_q, rb_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] p_q, p_d;
    logic        done_q, done_d;

    logic [3:0]  arr_x;
    logic [3:0]  arr_y;
    logic [7:0]  arr_pp;
    logic [15:0] pp_ext;
    logic [15:0] pp_shifted;
    logic [15:0] acc_sum;

    always_comb begin
        arr_x = ra_q[3:0];
        arr_y = rb_q[3:0];
        unique case (step_q)
            2'd0: begin arr_x = ra_q[3:0]; arr_y = rb_q[3:0]; end
            2'd1: begin arr_x = ra_q[7:4]; arr_y = rb_q[3:0]; end
            2'd2: begin arr_x = ra_q[3:0]; arr_y = rb_q[7:4]; end
            2'd3: begin arr_x = ra_q[7:4]; arr_y = rb_q[7:4]; end
        endcase
    end

    braun u_braun (
        .x    (arr_x),
        .y    (arr_y),
        .prod (arr_pp)
    );

    assign pp_ext = {8'h00, arr_pp};

    always_comb begin
        pp_shifted = pp_ext;
        unique case (step_q)
            2'd0:       pp_shifted = pp_ext;
            2'd1, 2'd2: pp_shifted = pp_ext << 4;
            2'd3:       pp_shifted = pp_ext << 8;
        endcase
    end

    // Cannot overflow: the largest full product is 0xFE01.
    assign acc_sum = acc_q + pp_shifted;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        step_d  = step_q;
        p_d     = p_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    acc_d   = 16'h0000;
                    step_d  = 2'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    p_d     = acc_sum;
                    done_d  = 1'b1;
                    state_d = StIdle;
                    step_d  = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ra_q    <= 8'h00;
            rb_q    <= 8'h00;
            acc_q   <= 16'h0000;
            step_q  <= 2'd0;
            p_q     <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_braun8_seq.sv
// Bench for braun8_seq: directed corners plus random operands against a plain a*b model.
// Inputs change and outputs are sampled on the falling edge.

module tb_braun8_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int unsigned n_pass;
    int unsigned n_total;
    logic [15:0] model_p;

    braun8_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Single operation from an idle negedge; expected product is plain integer arithmetic.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input string tag);
        logic [15:0] exp_p;
        exp_p = 16'(ta) * 16'(tb_v);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 16'(busy), 16'd1);
            chk({tag, "_nodone"}, 16'(done), 16'd0);
            chk({tag, "_hold_p"}, p, model_p);
            @(negedge clk);
        end
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_p"}, p, exp_p);
        chk({tag, "_idle"}, 16'(busy), 16'd0);
        model_p = exp_p;
        @(negedge clk);
        chk({tag, "_done_clr"}, 16'(done), 16'd0);
        chk({tag, "_p_kept"}, p, model_p);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        model_p = 16'h0000;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'hC3;

        // Reset overrides a simultaneous start.
        @(negedge clk);
        chk("rst_p", p, 16'h0000);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_p", p, 16'h0000);
            chk("idle_done", 16'(done), 16'd0);
            chk("idle_busy", 16'(busy), 16'd0);
        end

        do_op(8'h12, 8'h34, "basic");
        chk("basic_const", p, 16'h03A8);

        do_op(8'hFF, 8'hFF, "ffff");
        chk("ffff_const", p, 16'hFE01);
        do_op(8'hA5, 8'h0F, "a50f");
        chk("a50f_const", p, 16'h09AB);
        do_op(8'h00, 8'hC3, "zero");
        chk("zero_const", p, 16'h0000);
        do_op(8'h80, 8'h02, "msb");
        chk("msb_const", p, 16'h0100);

        // Start while busy is ignored and operands are not re-latched.
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sib_busy", 16'(busy), 16'd1);
        @(negedge clk);
        chk("sib_nodone", 16'(done), 16'd0);
        @(negedge clk);
        chk("sib_done", 16'(done), 16'd1);
        chk("sib_p", p, 16'h03A8);
        model_p = 16'h03A8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("sib_no2nd", 16'(done), 16'd0);
            chk("sib_idle", 16'(busy), 16'd0);
            chk("sib_p_kept", p, 16'h03A8);
        end

        // Back-to-back with start held high.
        a = 8'h10;
        b = 8'h10;
        start = 1'b1;
        @(negedge clk);
        a = 8'h03;
        b = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_p_old", p, 16'h03A8);
        end
        @(negedge clk);
        chk("b2b1_done", 16'(done), 16'd1);
        chk("b2b1_p", p, 16'h0100);
        @(negedge clk);
        start = 1'b0;
        chk("b2b2_busy", 16'(busy), 16'd1);
        chk("b2b2_nodone", 16'(done), 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b2_p_hold", p, 16'h0100);
            chk("b2b2_wait", 16'(done), 16'd0);
        end
        @(negedge clk);
        chk("b2b2_done", 16'(done), 16'd1);
        chk("b2b2_p", p, 16'h000F);
        model_p = 16'h000F;
        @(negedge clk);
        chk("b2b2_done_clr", 16'(done), 16'd0);

        // Reset mid-operation aborts without a done pulse.
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_p", p, 16'h0000);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_done", 16'(done), 16'd0);
        model_p = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_nodone", 16'(done), 16'd0);
            chk("abort_p_hold", p, 16'h0000);
        end
        do_op(8'h02, 8'h03, "post_rst");
        chk("post_rst_const", p, 16'h0006);

        for (int n = 0; n < 24; n++) begin
            do_op(8'($urandom), 8'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/braun8_seq.md
# braun8_seq

Sequential 8x8 unsigned multiplier controller built around one instance of the combinational 4x4 Braun array multiplier `braun`. It latches an 8-bit operand pair on a start request and feeds the four nibble-pair partial products through the shared 4x4 array over four clock cycles. Each product is shifted and accumulated into a 16-bit result, and the block signals completion with a one-cycle pulse. It sits between a requesting datapath/FSM and the 4x4 array, so wider products cost no extra array area.

## Interface
- Parameters: none. Operand width 8 and array width 4 are fixed.
- clk    input   1   rising-edge clock for all state
- rst    input   1   synchronous, active-high reset
- start  input   1   request; sampled only in IDLE
- a      input   8   multiplicand; captured on the edge that accepts start
- b      input   8   multiplier; captured on the edge that accepts start
- busy   output  1   high while an operation is in progress (RUN)
- done   output  1   registered one-cycle completion pulse
- p      output  16  registered product; holds last completed result

## Operation
- Internal registers:
  - ra[7:0], rb[7:0]: latched operands.
  - acc[15:0]: accumulator.
  - step[1:0]: partial-product index.
  - state: IDLE or RUN.
- One `braun` instance. Its x and y inputs are combinational muxes of ra/rb nibbles, selected by step.
- Step schedule (x, y, shift of the 8-bit partial product pp):
  - step 0: ra[3:0], rb[3:0], shift 0
  - step 1: ra[7:4], rb[3:0], shift 4
  - step 2: ra[3:0], rb[7:4], shift 4
  - step 3: ra[7:4], rb[7:4], shift 8
- pp is zero-extended to 16 bits before shifting.
  - acc never overflows: the maximum is 255*255 = 0xFE01.
  - Additions are truncated to 16 bits with no carry-out.
- IDLE:
  - start=1 causes: ra<=a, rb<=b, acc<=0, step<=0, state<=RUN.
  - start=0 causes: no change.
- RUN, each edge:
  - acc <= acc + (pp << shift(step)).
  - step <= step+1.
- RUN, edge with step=3:
  - p <= acc + (pp<<8), i.e. the final sum is written straight to p.
  - done<=1, state<=IDLE, step<=0.
- done is cleared on every edge that does not complete an operation.
- start while in RUN is ignored: no queueing, and operands are not re-latched.
- p is not cleared on start. It changes only on completion or reset.
- Reset:
  - state=IDLE, step=0, ra=rb=0, acc=0.
  - Outputs: p=0x0000, done=0, busy=0.
  - Reset overrides start in the same cycle.
- Reset mid-operation aborts the operation: no done pulse, and p returns to 0.

## Timing
- busy = (state==RUN), decoded combinationally from the registered state.
- busy rises immediately after the accepting edge and falls after the completing edge.
- Start accepted at edge k means:
  - RUN for edges k+1..k+4.
  - At edge k+4: p holds the product and done=1 for exactly one cycle (k+4 to k+5).
- Latency is 4 cycles from the accepting edge to done/p valid.
- Back-to-back operation:
  - start held high, or asserted during the done cycle, is accepted at edge k+5.
  - One result every 5 cycles.
- p from the previous operation stays stable throughout the next RUN.
- a and b may change freely after the accepting edge.

## Test plan
- Reset, then idle:
  - p=0x0000, done=0, busy=0 after the first edge with rst=1.
  - All three stay unchanged while start=0.
- a=0x12, b=0x34, start pulsed one cycle:
  - busy high for 4 cycles.
  - done pulses once at edge k+4 with p=0x03A8.
  - p holds 0x03A8 afterwards.
- Corner operands, each pair run separately:
  - 0xFF*0xFF gives p=0xFE01.
  - 0xA5*0x0F gives p=0x09AB.
  - 0x00*0xC3 gives p=0x0000.
  - 0x80*0x02 gives p=0x0100.
- Start while busy:
  - Accept 0x12*0x34, then pulse start with a=0xFF, b=0xFF at edge k+2.
  - Exactly one done at k+4, with p=0x03A8.
  - No second done follows.
- Back-to-back:
  - start held high with a=0x10, b=0x10 (first op), switched to 0x03*0x05 after the first accept.
  - p=0x0100 with done at k+4.
  - p=0x000F with done at k+9.
- Reset mid-operation:
  - Assert rst at edge k+2 of a 0xFF*0xFF operation.
  - No done pulse; p=0x0000, busy=0.
  - A new start of 0x02*0x03 yields p=0x0006.
